// File: rtl/pll_rst_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum (3-bit encoding is also the debug state_o value),
// retry counter width and lock-loss counter width.
package pll_rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   localparam int RETRY_W = 8;
   localparam int LOSS_W  = 16;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous level input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; level signal, sampled every cycle.
//
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
// RST_VAL sets the value both flops take while rst_n is low.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL supervisor: resets the PLL, qualifies its lock, then releases NUM_CH domain resets staggered.
// Latency: lock seen 2 cycles late (synchroniser); all outputs registered, change one edge after cause.
// Backpressure: none; restart is a single-cycle pulse honoured in any state with top priority.
//
// Ports: sys_clk, sys_rst_n (async active-low), restart, pll_lock (async raw lock)
//        -> pll_rst, ch_rst_n[NUM_CH-1:0], all_ready, fail, retry_cnt[7:0], state_o[2:0].
// Build option PLL_RST_SEQ_LOSS_CNT_EN adds loss_cnt[15:0] and loss_flag, which count and
// flag lock losses seen in RELEASE or RUN.
module pll_rst_seq
   import pll_rst_seq_pkg::*;
#(
   parameter int NUM_CH             = 4,
   parameter int PLL_RST_CYCLES     = 64,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int CH_GAP             = 16,
   parameter int MAX_RETRY          = 7
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               restart,
   input  logic               pll_lock,
   output logic               pll_rst,
   output logic [NUM_CH-1:0]  ch_rst_n,
   output logic               all_ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [2:0]         state_o
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   ,
   output logic [LOSS_W-1:0]  loss_cnt,
   output logic               loss_flag
`endif
);

   // One shared phase counter: it clears on every state change, so its
   // width only has to cover the longest phase.
   localparam int REL_LAST = (NUM_CH - 1) * CH_GAP;
   localparam int M1       = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int M2       = (LOCK_STABLE_CYCLES > REL_LAST) ? LOCK_STABLE_CYCLES : REL_LAST;
   localparam int CNT_MAX  = (M1 > M2) ? M1 : M2;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_END    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_END     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(LOCK_STABLE_CYCLES - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CNT_W:0]     cnt_p1;
   logic [RETRY_W-1:0] retry_nxt;
   logic [NUM_CH-1:0]  rel_mask;
   logic [NUM_CH-1:0]  ch_nxt;
   logic               lock_s;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   logic               loss_evt;
`endif

   sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      cnt_nxt   = cnt;
      ch_nxt    = '0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      loss_evt  = 1'b0;
`endif

      // Release pattern for the cycle after this one: bit k is due once
      // k*CH_GAP cycles of RELEASE have elapsed. Bit 0 is due at entry.
      cnt_p1      = {1'b0, cnt} + (CNT_W+1)'(1);
      rel_mask    = '0;
      rel_mask[0] = 1'b1;
      for (int k = 1; k < NUM_CH; k++) begin
         rel_mask[k] = (cnt_p1 >= (CNT_W+1)'(k * CH_GAP));
      end

      if (restart) begin
         state_nxt = ST_RESET_PLL;
         retry_nxt = '0;
      end else begin
         case (state)
            ST_RESET_PLL: begin
               if (cnt == RST_END) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = ST_STABLE;
               end else if (cnt == TO_END) begin
                  retry_nxt = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_W'(1);
                  state_nxt = (retry_nxt > RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_RESET_PLL;
               end
            end
            ST_STABLE: begin
               // A dropout only restarts the lock wait; it is not a retry.
               if (!lock_s) begin
                  state_nxt = ST_WAIT_LOCK;
               end else if (cnt == STABLE_END) begin
                  state_nxt = ST_RELEASE;
                  retry_nxt = '0;
               end
            end
            ST_RELEASE, ST_RUN: begin
               if (!lock_s) begin
                  state_nxt = ST_RESET_PLL;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
                  loss_evt  = 1'b1;
`endif
               end else if (state == ST_RELEASE && rel_mask[NUM_CH-1]) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_FAIL: ;
            default: state_nxt = ST_RESET_PLL;
         endcase
      end

      // Restart also re-times the phase even when already in RESET_PLL.
      if (restart || (state_nxt != state)) begin
         cnt_nxt = '0;
      end else if (cnt != '1) begin
         cnt_nxt = cnt + CNT_W'(1);
      end

      case (state_nxt)
         ST_RELEASE: ch_nxt = (state == ST_RELEASE) ? rel_mask : NUM_CH'(1);
         ST_RUN:     ch_nxt = '1;
         default:    ch_nxt = '0;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_RESET_PLL;
         cnt       <= '0;
         retry_cnt <= '0;
         ch_rst_n  <= '0;
         pll_rst   <= 1'b1;
         all_ready <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         retry_cnt <= retry_nxt;
         ch_rst_n  <= ch_nxt;
         pll_rst   <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
         all_ready <= (state_nxt == ST_RUN);
         fail      <= (state_nxt == ST_FAIL);
      end
   end

   assign state_o = state;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         loss_cnt  <= '0;
         loss_flag <= 1'b0;
      end else begin
         loss_flag <= loss_evt;
         if (restart) begin
            loss_cnt <= '0;
         end else if (loss_evt && (loss_cnt != '1)) begin
            loss_cnt <= loss_cnt + LOSS_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: a 4-channel and a 1-channel instance share one stimulus stream.
// Latency: outputs compared every cycle on the falling edge against a phase/elapsed-time model.
// Backpressure: n/a.
module tb_pll_rst_seq;

   localparam int PLL_RST_CYCLES     = 4;
   localparam int LOCK_STABLE_CYCLES = 8;
   localparam int LOCK_TIMEOUT       = 32;
   localparam int CH_GAP             = 3;
   localparam int MAX_RETRY          = 2;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       restart;
   logic       pll_lock;

   logic       pll_rst0, all_ready0, fail0;
   logic [3:0] ch0;
   logic [7:0] retry0;
   logic [2:0] state0;
   logic       pll_rst1, all_ready1, fail1;
   logic [0:0] ch1;
   logic [7:0] retry1;
   logic [2:0] state1;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   logic [15:0] loss_cnt0, loss_cnt1;
   logic        loss_flag0, loss_flag1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   pll_rst_seq #(
      .NUM_CH(4), .PLL_RST_CYCLES(PLL_RST_CYCLES), .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT), .CH_GAP(CH_GAP), .MAX_RETRY(MAX_RETRY)
   ) u_dut4 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .restart(restart), .pll_lock(pll_lock),
      .pll_rst(pll_rst0), .ch_rst_n(ch0), .all_ready(all_ready0), .fail(fail0),
      .retry_cnt(retry0), .state_o(state0)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      , .loss_cnt(loss_cnt0), .loss_flag(loss_flag0)
`endif
   );

   pll_rst_seq #(
      .NUM_CH(1), .PLL_RST_CYCLES(PLL_RST_CYCLES), .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT), .CH_GAP(CH_GAP), .MAX_RETRY(MAX_RETRY)
   ) u_dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .restart(restart), .pll_lock(pll_lock),
      .pll_rst(pll_rst1), .ch_rst_n(ch1), .all_ready(all_ready1), .fail(fail1),
      .retry_cnt(retry1), .state_o(state1)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      , .loss_cnt(loss_cnt1), .loss_flag(loss_flag1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model. Each instance is described by its phase (the state
   // number), how many clock edges it has spent in that phase, its retry
   // tally and its loss tally. The lock pipeline is shared.
   int ph[2], el[2], rtr[2], lcnt[2];
   bit lflag[2];
   bit s1, s2;

   function automatic int nch(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic model_reset();
      s1 = 0; s2 = 0;
      for (int i = 0; i < 2; i++) begin
         ph[i] = 0; el[i] = 0; rtr[i] = 0; lcnt[i] = 0; lflag[i] = 0;
      end
   endtask

   task automatic model_edge(input bit rs, input bit lk);
      bit ls;
      ls = s2; s2 = s1; s1 = lk;
      for (int i = 0; i < 2; i++) begin
         int np, done_after;
         np = ph[i];
         lflag[i] = 0;
         if (rs) begin
            np = 0; rtr[i] = 0; lcnt[i] = 0;
         end else begin
            case (ph[i])
               0: if (el[i] + 1 == PLL_RST_CYCLES) np = 1;
               1: if (ls) np = 2;
                  else if (el[i] + 1 == LOCK_TIMEOUT) begin
                     rtr[i] = (rtr[i] < 255) ? rtr[i] + 1 : 255;
                     np = (rtr[i] > MAX_RETRY) ? 5 : 0;
                  end
               2: if (!ls) np = 1;
                  else if (el[i] + 1 == LOCK_STABLE_CYCLES) begin np = 3; rtr[i] = 0; end
               3, 4: if (!ls) begin
                     np = 0; lflag[i] = 1;
                     if (lcnt[i] < 65535) lcnt[i]++;
                  end else if (ph[i] == 3) begin
                     // number of channels released after this edge
                     done_after = (el[i] + 1) / CH_GAP + 1;
                     if (done_after >= nch(i)) np = 4;
                  end
               default: ;
            endcase
         end
         if (rs || np != ph[i]) el[i] = 0;
         else el[i]++;
         ph[i] = np;
      end
   endtask

   function automatic logic [31:0] exp_ch(input int i);
      int n;
      if (ph[i] == 4) n = nch(i);
      else if (ph[i] == 3) n = (el[i] / CH_GAP + 1 > nch(i)) ? nch(i) : el[i] / CH_GAP + 1;
      else n = 0;
      return (32'd1 << n) - 32'd1;
   endfunction

   task automatic cmp_inst(input int i, input logic pr, input logic [31:0] ch, input logic ar,
                           input logic fl, input logic [7:0] rc, input logic [2:0] st);
      chk($sformatf("u%0d_pll_rst", i), {31'd0, pr}, (ph[i] == 0 || ph[i] == 5) ? 1 : 0);
      chk($sformatf("u%0d_ch_rst_n", i), ch, exp_ch(i));
      chk($sformatf("u%0d_all_ready", i), {31'd0, ar}, (ph[i] == 4) ? 1 : 0);
      chk($sformatf("u%0d_fail", i), {31'd0, fl}, (ph[i] == 5) ? 1 : 0);
      chk($sformatf("u%0d_retry_cnt", i), {24'd0, rc}, rtr[i]);
      chk($sformatf("u%0d_state", i), {29'd0, st}, ph[i]);
   endtask

   task automatic compare_all();
      cmp_inst(0, pll_rst0, {28'd0, ch0}, all_ready0, fail0, retry0, state0);
      cmp_inst(1, pll_rst1, {31'd0, ch1}, all_ready1, fail1, retry1, state1);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      chk("u0_loss_cnt", {16'd0, loss_cnt0}, lcnt[0]);
      chk("u0_loss_flag", {31'd0, loss_flag0}, lflag[0]);
      chk("u1_loss_cnt", {16'd0, loss_cnt1}, lcnt[1]);
      chk("u1_loss_flag", {31'd0, loss_flag1}, lflag[1]);
`endif
   endtask

   // One clock: inputs held across the rising edge, outputs compared on the falling edge.
   task automatic step(input bit rs, input bit lk);
      restart  = rs;
      pll_lock = lk;
      @(posedge sys_clk);
      model_edge(rs, lk);
      @(negedge sys_clk);
      compare_all();
   endtask

   task automatic wait_state(input logic [2:0] st, input bit lk, input int budget);
      int n = 0;
      while (state0 !== st && n < budget) begin step(0, lk); n++; end
      chk("wait_state", {29'd0, state0}, {29'd0, st});
   endtask

   initial begin
      int pr_hi, t, n_rel1;
      logic [3:0] prev_ch;
      logic [3:0] ch_vals[$];
      int ch_times[$];
      int ar_time;

      sys_rst_n = 1'b0; restart = 1'b0; pll_lock = 1'b0;
      model_reset();
      repeat (3) @(negedge sys_clk);
      chk("reset_pll_rst", {31'd0, pll_rst0}, 1);
      chk("reset_ch", {28'd0, ch0}, 0);
      chk("reset_state", {29'd0, state0}, 0);
      compare_all();
      sys_rst_n = 1'b1;

      // 1: nominal bring-up, lock raised after 10 cycles
      pr_hi = pll_rst0 ? 1 : 0;
      for (int c = 0; c < 10; c++) begin
         step(0, 0);
         if (pll_rst0) pr_hi++;
      end
      chk("bringup_pll_rst_len", pr_hi, PLL_RST_CYCLES);
      prev_ch = ch0; ar_time = -1; n_rel1 = 0;
      for (t = 0; t < 40; t++) begin
         step(0, 1);
         if (ch0 !== prev_ch) begin ch_vals.push_back(ch0); ch_times.push_back(t); end
         if (all_ready0 && ar_time < 0) ar_time = t;
         if (state1 == 3'd3) n_rel1++;
         prev_ch = ch0;
      end
      chk("bringup_ch_steps", ch_vals.size(), 4);
      if (ch_vals.size() == 4) begin
         chk("bringup_ch0", {28'd0, ch_vals[0]}, 4'b0001);
         chk("bringup_ch1", {28'd0, ch_vals[1]}, 4'b0011);
         chk("bringup_ch2", {28'd0, ch_vals[2]}, 4'b0111);
         chk("bringup_ch3", {28'd0, ch_vals[3]}, 4'b1111);
         for (int k = 1; k < 4; k++) chk("bringup_gap", ch_times[k] - ch_times[k-1], CH_GAP);
         chk("bringup_ready_with_bit3", ar_time, ch_times[3]);
      end
      chk("bringup_retry", {24'd0, retry0}, 0);
      chk("one_ch_release_len", n_rel1, 1);

      // 2: one-cycle lock dropout in STABLE after 5 stable cycles
      step(1, 1);
      wait_state(3'd2, 1, 50);
      repeat (4) step(0, 1);
      step(0, 0);
      repeat (30) step(0, 1);
      chk("glitch_retry", {24'd0, retry0}, 0);

      // 3: repeated timeouts into FAIL, then restart
      step(1, 0);
      repeat (120) step(0, 0);
      chk("timeout_fail", {31'd0, fail0}, 1);
      chk("timeout_retry", {24'd0, retry0}, 3);
      chk("timeout_pll_rst", {31'd0, pll_rst0}, 1);
      step(1, 0);
      chk("restart_fail", {31'd0, fail0}, 0);
      chk("restart_retry", {24'd0, retry0}, 0);
      chk("restart_state", {29'd0, state0}, 0);

      // 4: lock loss in RUN
      step(0, 1);
      wait_state(3'd4, 1, 60);
      step(0, 0); step(0, 0);
      chk("loss_sync_hold", {31'd0, all_ready0}, 1);
      step(0, 0);
      chk("loss_ch", {28'd0, ch0}, 0);
      chk("loss_ready", {31'd0, all_ready0}, 0);
      chk("loss_state", {29'd0, state0}, 0);
      repeat (6) step(0, 0);

      // 5: restart on the same edge that sees lock fall during RELEASE
      step(1, 1);
      wait_state(3'd3, 1, 60);
      step(0, 0); step(0, 0); step(1, 0);
      chk("simul_state", {29'd0, state0}, 0);
      chk("simul_retry", {24'd0, retry0}, 0);

      // 6: async reset mid-RELEASE
      step(0, 1);
      wait_state(3'd3, 1, 60);
      t = 0;
      while (ch0 !== 4'b0011 && t < 20) begin step(0, 1); t++; end
      chk("pre_async_ch", {28'd0, ch0}, 4'b0011);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("async_ch", {28'd0, ch0}, 0);
      chk("async_pll_rst", {31'd0, pll_rst0}, 1);
      model_reset();
      @(negedge sys_clk);
      compare_all();
      sys_rst_n = 1'b1;

      // randomized lock on/off segments with sparse restart pulses
      for (int seg = 0; seg < 60; seg++) begin
         bit lv;
         int len;
         lv  = 1'($urandom_range(0, 1));
         len = lv ? $urandom_range(1, 60) : $urandom_range(1, 140);
         for (int c = 0; c < len; c++) step($urandom_range(0, 99) == 0, lv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
